// File: rtl/zeroheti_irq_pkg.sv
// zeroheti_irq_pkg
// Shared types and constants for the zeroheti interrupt arbiter.
//   irq_fsm_e : offer state machine encoding (IDLE, OFFER, GAP)
//   irq_cfg_t : per-line configuration record {ie, is_edge, prio}
//   MaxIrq    : largest supported number of interrupt lines
//   PrioW     : default priority field width
package zeroheti_irq_pkg;

  localparam int MaxIrq = 64;
  localparam int PrioW  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2
  } irq_fsm_e;

  // Software view of one line's configuration. `edge` is a reserved word,
  // hence is_edge.
  typedef struct packed {
    logic             ie;
    logic             is_edge;
    logic [PrioW-1:0] prio;
  } irq_cfg_t;

endpackage

// File: rtl/zeroheti_irq_prio_tree.sv
// zeroheti_irq_prio_tree
// Purely combinational pairwise max tree over N candidates.
//   i_cand  : candidate vector (one bit per line)
//   i_prio  : flattened priorities, line i at [i*PRIO_W +: PRIO_W]
//   o_valid : at least one candidate present
//   o_id    : index of the winner (highest prio, lowest index on ties)
//   o_prio  : priority of the winner
module zeroheti_irq_prio_tree #(
  parameter int N      = 16,
  parameter int PRIO_W = 3,
  parameter int ID_W   = $clog2(N)
) (
  input  logic [N-1:0]        i_cand,
  input  logic [N*PRIO_W-1:0] i_prio,
  output logic                o_valid,
  output logic [ID_W-1:0]     o_id,
  output logic [PRIO_W-1:0]   o_prio
);

  // Heap-ordered tree padded to a power of two: node k has children 2k and
  // 2k+1, leaves sit at P..2P-1 in line order.
  localparam int Lvl = (N > 1) ? $clog2(N) : 1;
  localparam int P   = 1 << Lvl;

  logic              w_v  [1:2*P-1];
  logic [ID_W-1:0]   w_id [1:2*P-1];
  logic [PRIO_W-1:0] w_pr [1:2*P-1];

  for (genvar g = 0; g < P; g++) begin : g_leaf
    if (g < N) begin : g_real
      assign w_v[P+g]  = i_cand[g];
      assign w_id[P+g] = ID_W'(g);
      assign w_pr[P+g] = i_prio[g*PRIO_W +: PRIO_W];
    end else begin : g_pad
      assign w_v[P+g]  = 1'b0;
      assign w_id[P+g] = '0;
      assign w_pr[P+g] = '0;
    end
  end

  // The left child always covers lower indices, so the right child only
  // wins with a strictly higher priority.
  for (genvar k = 1; k < P; k++) begin : g_node
    logic w_take_r;
    assign w_take_r = w_v[2*k+1] && (!w_v[2*k] || (w_pr[2*k+1] > w_pr[2*k]));
    assign w_v[k]   = w_v[2*k] | w_v[2*k+1];
    assign w_id[k]  = w_take_r ? w_id[2*k+1] : w_id[2*k];
    assign w_pr[k]  = w_take_r ? w_pr[2*k+1] : w_pr[2*k];
  end

  assign o_valid = w_v[1];
  assign o_id    = w_id[1];
  assign o_prio  = w_pr[1];

endmodule

// File: rtl/zeroheti_irq_arbiter.sv
// zeroheti_irq_arbiter
// Interrupt front end for zeroheti_core: latches interrupt lines as pending
// (edge or level per line), picks the highest-priority enabled pending line
// above the core threshold and offers it over a valid/ready handshake.
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   irq_i                  : interrupt lines (synchronous to clk_i)
//   cfg_we_i/idx/ie/edge/prio : per-line configuration write port
//   thresh_i               : core's current interrupt level
//   irq_valid_o/id/prio    : offer to the core
//   irq_ready_i            : core accepts the offer
//   claim_o                : one-cycle pulse on handshake
//   pend_o                 : pending vector for debug/CSR read
// Optional build macro ZEROHETI_IRQ_REOFFER_EN: while an offer waits with
// ready low, a strictly higher-priority candidate replaces id/prio in place.
//
// Handshake: a transfer happens in a cycle where irq_valid_o & irq_ready_i;
// once raised, irq_valid_o stays high and id/prio stay stable until that
// transfer (except for the optional replacement above); irq_ready_i with
// irq_valid_o low has no effect.
module zeroheti_irq_arbiter
  import zeroheti_irq_pkg::*;
#(
  parameter int  NUM_IRQ = 16,
  parameter int  PRIO_W  = PrioW,
  localparam int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               cfg_we_i,
  input  logic [ID_W-1:0]    cfg_idx_i,
  input  logic               cfg_ie_i,
  input  logic               cfg_edge_i,
  input  logic [PRIO_W-1:0]  cfg_prio_i,
  input  logic [PRIO_W-1:0]  thresh_i,
  output logic               irq_valid_o,
  output logic [ID_W-1:0]    irq_id_o,
  output logic [PRIO_W-1:0]  irq_prio_o,
  input  logic               irq_ready_i,
  output logic               claim_o,
  output logic [NUM_IRQ-1:0] pend_o
);

  localparam logic [ID_W:0] NumIrqW = (ID_W+1)'(NUM_IRQ);

  logic [NUM_IRQ-1:0]   r_ie, r_edge, r_irq_q, r_pend;
  logic [PRIO_W-1:0]    r_prio [NUM_IRQ];
  irq_fsm_e             r_state, w_state_nxt;
  logic [ID_W-1:0]      r_off_id;
  logic [PRIO_W-1:0]    r_off_prio;

  logic                 w_cfg_hit;
  logic [NUM_IRQ-1:0]   w_pend_nxt, w_cand;
  logic [NUM_IRQ*PRIO_W-1:0] w_prio_flat;
  logic                 w_win_valid;
  logic [ID_W-1:0]      w_win_id;
  logic [PRIO_W-1:0]    w_win_prio;
  logic                 w_offer_valid, w_claim, w_load;

  // Writes to non-existent lines are dropped.
  assign w_cfg_hit = cfg_we_i && ({1'b0, cfg_idx_i} < NumIrqW);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ie   <= '0;
      r_edge <= '0;
      for (int i = 0; i < NUM_IRQ; i++) r_prio[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (w_cfg_hit && (cfg_idx_i == ID_W'(i))) begin
          r_ie[i]   <= cfg_ie_i;
          r_edge[i] <= cfg_edge_i;
          r_prio[i] <= cfg_prio_i;
        end
      end
    end
  end

  // Edge lines: claim clears, but a fresh edge in the claim cycle wins.
  // Level lines: pending is the line registered once.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (r_edge[i]) begin
        if (w_claim && (r_off_id == ID_W'(i))) w_pend_nxt[i] = 1'b0;
        if (irq_i[i] && !r_irq_q[i])           w_pend_nxt[i] = 1'b1;
      end else begin
        w_pend_nxt[i] = irq_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_irq_q <= '0;
      r_pend  <= '0;
    end else begin
      r_irq_q <= irq_i;
      r_pend  <= w_pend_nxt;
    end
  end

  // Enable only gates arbitration; pending is recorded regardless.
  always_comb begin
    w_cand      = '0;
    w_prio_flat = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_cand[i] = r_pend[i] && r_ie[i] && (r_prio[i] > thresh_i);
      w_prio_flat[i*PRIO_W +: PRIO_W] = r_prio[i];
    end
  end

  zeroheti_irq_prio_tree #(
    .N      (NUM_IRQ),
    .PRIO_W (PRIO_W),
    .ID_W   (ID_W)
  ) u_prio_tree (
    .i_cand  (w_cand),
    .i_prio  (w_prio_flat),
    .o_valid (w_win_valid),
    .o_id    (w_win_id),
    .o_prio  (w_win_prio)
  );

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state. GAP gives the core one cycle to raise thresh_i.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_win_valid) w_state_nxt = OFFER;
      OFFER:   if (irq_ready_i) w_state_nxt = GAP;
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_offer_valid = (r_state == OFFER);
    w_claim       = w_offer_valid && irq_ready_i;
    w_load        = (r_state == IDLE) && w_win_valid;
`ifdef ZEROHETI_IRQ_REOFFER_EN
    if (w_offer_valid && !irq_ready_i && w_win_valid && (w_win_prio > r_off_prio))
      w_load = 1'b1;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_off_id   <= '0;
      r_off_prio <= '0;
    end else if (w_load) begin
      r_off_id   <= w_win_id;
      r_off_prio <= w_win_prio;
    end
  end

  assign irq_valid_o = w_offer_valid;
  assign irq_id_o    = r_off_id;
  assign irq_prio_o  = r_off_prio;
  assign claim_o     = w_claim;
  assign pend_o      = r_pend;

endmodule

// File: doc/zeroheti_irq_arbiter.md
Name: zeroheti_irq_arbiter

Overview:
- Interrupt front end sitting directly upstream of zeroheti_core.
- Captures external interrupt lines and latches them as pending (edge or level per line).
- Selects the highest-priority enabled pending line above the core's current threshold and offers it to the core over a valid/ready handshake.
- The core claims an interrupt on handshake; edge pending bits clear on claim.

Parameters:
- NUM_IRQ, 16, number of interrupt lines; legal range 2..64.
- PRIO_W, 3, priority field width; priority 0 means never taken.
- ID_W, $clog2(NUM_IRQ), width of line index (derived, not overridden).

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous active-high reset
- irq_i  in  NUM_IRQ  interrupt lines, already synchronous to clk_i
- cfg_we_i  in  1  configuration write strobe
- cfg_idx_i  in  ID_W  line being configured
- cfg_ie_i  in  1  enable bit for the line
- cfg_edge_i  in  1  trigger: 1=rising edge, 0=level
- cfg_prio_i  in  PRIO_W  priority for the line
- thresh_i  in  PRIO_W  core's current interrupt level
- irq_valid_o  out  1  offer to core
- irq_id_o  out  ID_W  offered line index
- irq_prio_o  out  PRIO_W  offered line priority
- irq_ready_i  in  1  core accepts the offer
- claim_o  out  1  one-cycle pulse on handshake
- pend_o  out  NUM_IRQ  pending vector, for debug/CSR read

Behaviour:
- Reset (asynchronous, rst_i=1):
  - All ie/edge/prio registers, pending bits and the irq_i history register go to 0.
  - Outputs: irq_valid_o=0, irq_id_o=0, irq_prio_o=0, claim_o=0, pend_o=0.
  - FSM goes to IDLE.
  - Reset mid-offer drops the offer immediately; no claim is generated.
- Configuration:
  - cfg_we_i updates the line's fields at the clock edge.
  - A cfg_idx_i value >= NUM_IRQ is ignored.
  - A write never retracts an offer already in progress.
- Pending:
  - Edge lines: pending sets when irq_i=1 and the previous-cycle sample=0.
  - Level lines: pending follows irq_i, registered with 1 cycle latency.
  - Pending is recorded regardless of ie. Enable gates arbitration only.
- Arbitration (combinational over the registered pending/config state):
  - Candidates: pending & ie & (prio > thresh_i, unsigned).
  - Winner: highest prio; ties go to the lowest index.
- FSM:
  - IDLE: if a winner exists, register id/prio, raise irq_valid_o, go to OFFER. Minimum latency is 2 cycles from the irq_i edge to irq_valid_o.
  - OFFER: irq_valid_o, irq_id_o and irq_prio_o are held stable until irq_valid_o & irq_ready_i.
    - On handshake: claim_o=1 that cycle. If the claimed line is edge, clear its pending bit. A new edge on the same line in that same cycle wins, and the bit stays set.
    - Then drop irq_valid_o and go to GAP.
    - A rise in thresh_i during OFFER does not retract the offer; the core re-checks.
  - GAP: one idle cycle so the core's new thresh_i is seen; then IDLE.
  - Consequence: back-to-back offers are at least 2 cycles apart.
- Level lines are not cleared on claim. The core must silence the source before returning, otherwise the line is re-offered.
- irq_ready_i while irq_valid_o=0 is ignored.

Optional Feature:
- Macro: ZEROHETI_IRQ_REOFFER_EN.
- Defined: in OFFER without a handshake, if a candidate with strictly higher prio than irq_prio_o exists, irq_id_o/irq_prio_o are replaced next cycle. irq_valid_o stays high, and the stability rule is relaxed to "stable only while ready=0 and no higher candidate."
- Undefined: the offer is strictly stable until the handshake, as specified above.

Decomposition:
- Package zeroheti_irq_pkg holds:
  - irq_fsm_e enum (IDLE, OFFER, GAP)
  - irq_cfg_t struct {ie, edge, prio}
  - MaxIrq=64 constant
  - PrioW default
- One sub-module, zeroheti_irq_prio_tree: a parameterised pairwise max tree producing {valid, id, prio} from the candidate vector. It is purely combinational, with lowest index winning on ties.

Test Plan:
- Line 3: edge, prio 5, ie. thresh_i=0; pulse irq_i[3] for 1 cycle -> irq_valid_o=1 two cycles later with id=3, prio=5. ready=1 -> claim_o pulse, pend_o[3]=0, valid low for 2 cycles.
- Lines 2 and 7 both prio 4, and line 9 prio 6, all pending together -> id=9 offered first. After claim, id=2 (tie goes to lowest index), then id=7.
- Line 1 level, prio 3. thresh_i=3 -> no offer. Lower thresh_i to 2 -> offer id=1. Claim with irq_i[1] still high -> re-offered after GAP.
- Offer id=4, prio 2, held with ready=0 for 10 cycles while line 5 (prio 7) pends:
  - Without the macro: id stays 4 for all 10 cycles.
  - With ZEROHETI_IRQ_REOFFER_EN: id=5 on the next cycle.
- Edge line 6 claimed in the same cycle a new rising edge arrives -> pend_o[6] remains 1 and is re-offered after GAP.
- Assert rst_i mid-OFFER -> irq_valid_o=0 and pend_o=0 asynchronously, no claim_o. cfg_we_i with cfg_idx_i=NUM_IRQ -> no config change.
